// File: rtl/imem_loader_pkg.sv
// Shared constants, loader state type and start-legality helper for the
// instruction-memory loader slice.
package imem_loader_pkg;

  localparam int unsigned MEM_BYTES   = 2048;
  localparam int unsigned AW          = 11;
  localparam int unsigned FETCH_BYTES = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;

  // Base+len is summed in 65 bits so a huge base cannot wrap into range.
  function automatic logic start_legal(input logic [63:0] base, input logic [63:0] len);
    logic [64:0] end_addr;
    end_addr = {1'b0, base} + {1'b0, len};
    return (len != '0) && (end_addr <= 65'(MEM_BYTES));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host loader (master) and imem_loader (slave).
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;

  modport master (output in_valid, output in_byte, input  in_ready);
  modport slave  (input  in_valid, input  in_byte, output in_ready);
endinterface

// File: rtl/imem_array.sv
// Byte-addressed instruction RAM: one synchronous write port and a
// FETCH_BYTES-wide combinational read with per-byte out-of-range zeroing.
module imem_array
  import imem_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [7:0]                 wdata_i,
  input  logic [63:0]                raddr_i,
  output logic [8*FETCH_BYTES-1:0]   rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];
  logic [AW:0] idx;

  // Write port; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Fetch window; bytes past the end of memory read as zero, never alias.
  always_comb begin
    rdata_o = '0;
    idx     = '0;
    if (raddr_i < 64'(MEM_BYTES)) begin
      for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
        idx = {1'b0, raddr_i[AW-1:0]} + (AW+1)'(k);
        if (idx < (AW+1)'(MEM_BYTES)) begin
          rdata_o[8*k +: 8] = mem_q[idx[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream into imem, holds the core
// off until the image is complete, and serves the fetch stage's 10-byte read.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic [63:0]               load_base,
  input  logic [63:0]               load_len,
  imem_loader_if.slave              s_if,
  output logic                      core_run,
  output logic                      load_err,
  output logic [63:0]               bytes_loaded,
  output logic [7:0]                load_csum,
  input  logic [63:0]               PC,
  output logic [8*FETCH_BYTES-1:0]  fetch_bytes,
  output logic                      imem_er
);

  ld_state_e     state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   rem_q;
  logic [63:0]   bytes_q;
  logic [7:0]    csum_q;
  logic          run_q;
  logic          err_q;

  logic loading_d;
  logic xfer_d;
  logic start_ok_d;

  assign loading_d  = (state_q == ST_LOAD);
  assign xfer_d     = loading_d & s_if.in_valid;
  assign start_ok_d = start_legal(load_base, load_len);

  assign s_if.in_ready = loading_d;
  assign core_run      = run_q;
  assign load_err      = err_q;
  assign bytes_loaded  = bytes_q;
  assign load_csum     = csum_q;
  assign imem_er       = (PC >= 64'(MEM_BYTES));

  // Loader FSM with pointer, remaining count, byte counter and XOR checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      bytes_q <= '0;
      csum_q  <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer_d) begin
            ptr_q   <= ptr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            bytes_q <= bytes_q + 64'd1;
            csum_q  <= csum_q ^ s_if.in_byte;
            if (rem_q == (AW+1)'(1)) begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        default: begin
          if (load_start) begin
            if (start_ok_d) begin
              state_q <= ST_LOAD;
              ptr_q   <= load_base[AW-1:0];
              rem_q   <= load_len[AW:0];
              bytes_q <= '0;
              csum_q  <= '0;
              run_q   <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              run_q   <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  imem_array u_array (
    .clk     (clk),
    .we_i    (xfer_d),
    .waddr_i (ptr_q),
    .wdata_i (s_if.in_byte),
    .raddr_i (PC),
    .rdata_o (fetch_bytes)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, compared against a byte-array reference model of the loader.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [63:0] load_base;
  logic [63:0] load_len;
  logic        core_run;
  logic        load_err;
  logic [63:0] bytes_loaded;
  logic [7:0]  load_csum;
  logic [63:0] PC;
  logic [79:0] fetch_bytes;
  logic        imem_er;

  imem_loader_if bus ();

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_base    (load_base),
    .load_len     (load_len),
    .s_if         (bus),
    .core_run     (core_run),
    .load_err     (load_err),
    .bytes_loaded (bytes_loaded),
    .load_csum    (load_csum),
    .PC           (PC),
    .fetch_bytes  (fetch_bytes),
    .imem_er      (imem_er)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [7:0]  m_mem   [2048];
  bit          m_known [2048];
  bit          m_loading, m_run, m_err;
  longint unsigned m_ptr, m_rem, m_bytes;
  logic [7:0]  m_csum;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_loading = 0; m_run = 0; m_err = 0;
    m_ptr = 0; m_rem = 0; m_bytes = 0; m_csum = 8'h00;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".in_ready"}, 80'(bus.in_ready), 80'(m_loading));
    chk({tag, ".core_run"}, 80'(core_run), 80'(m_run));
    chk({tag, ".load_err"}, 80'(load_err), 80'(m_err));
    chk({tag, ".bytes"}, 80'(bytes_loaded), 80'(m_bytes));
    chk({tag, ".csum"}, 80'(load_csum), 80'(m_csum));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_status("reset");
  endtask

  task automatic do_start(input logic [63:0] base, input logic [63:0] len);
    logic [64:0] e;
    load_base = base; load_len = len; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    e = {1'b0, base} + {1'b0, len};
    if (!m_loading) begin
      if (len != 0 && e <= 65'd2048) begin
        m_loading = 1; m_run = 0; m_err = 0;
        m_ptr = base; m_rem = len; m_bytes = 0; m_csum = 8'h00;
      end else begin
        m_loading = 0; m_run = 0; m_err = 1;
      end
    end
    check_status("start");
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.in_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin
      tick();
      chk("gap.in_ready", 80'(bus.in_ready), 80'(m_loading));
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    tick();
    bus.in_valid = 1'b0;
    if (m_loading) begin
      m_mem[m_ptr]   = b;
      m_known[m_ptr] = 1;
      m_ptr++; m_rem--; m_bytes++;
      m_csum = m_csum ^ b;
      if (m_rem == 0) begin
        m_loading = 0;
        m_run     = 1;
      end
    end
    check_status("xfer");
  endtask

  task automatic check_fetch(input logic [63:0] pc, input string tag);
    logic [79:0] exp, mask;
    longint unsigned a;
    PC = pc;
    #1;
    exp = '0; mask = '0;
    for (int k = 0; k < 10; k++) begin
      if (pc < 64'd2048) begin
        a = pc + 64'(k);
        if (a < 2048) begin
          if (m_known[a]) begin
            exp[8*k +: 8]  = m_mem[a];
            mask[8*k +: 8] = 8'hFF;
          end
        end else begin
          mask[8*k +: 8] = 8'hFF;
        end
      end else begin
        mask[8*k +: 8] = 8'hFF;
      end
    end
    chk({tag, ".bytes"}, fetch_bytes & mask, exp & mask);
    chk({tag, ".imem_er"}, 80'(imem_er), 80'(pc >= 64'd2048));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [10];
    logic [63:0] base, len;
    t1 = '{8'h30, 8'hF3, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 2048; i++) begin
      m_known[i] = 0;
      m_mem[i]   = 8'h00;
    end
    model_reset();
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0; PC = '0;
    bus.in_valid = 1'b0; bus.in_byte = 8'h00;
    tick();
    do_reset();

    // 1: 10-byte image at 0
    do_start(64'd0, 64'd10);
    for (int i = 0; i < 10; i++) send_byte(t1[i], 0);
    chk("t1.csum_const", 80'(load_csum), 80'hCB);
    check_fetch(64'd0, "t1.fetch");
    chk("t1.fetch_const", fetch_bytes, 80'h0000_0000_0000_0008_F330);

    // 2: gappy stream, len 4
    do_start(64'd100, 64'd4);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 2);
    check_fetch(64'd100, "t2.fetch");

    // stray byte in RUN is dropped
    send_byte(8'h5A, 0);

    // 3: illegal starts, then legal load at top of memory
    do_start(64'd2040, 64'd8);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 0);
    do_start(64'd2040, 64'd9);
    send_byte(8'hEE, 0);
    check_fetch(64'd2040, "t3.after_err");
    do_start(64'd0, 64'd0);
    do_start(64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    do_start(64'd2040, 64'd8);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 1));

    // 4: fetch window at the top boundary and beyond
    check_fetch(64'd2044, "t4.pc2044");
    check_fetch(64'd2047, "t4.pc2047");
    check_fetch(64'd2048, "t4.pc2048");
    chk("t4.pc2048_zero", fetch_bytes, 80'h0);
    check_fetch(64'h8000_0000_0000_0000, "t4.pc_huge");

    // 5: restart ignored mid-load, then reset abandons load
    do_start(64'd300, 64'd8);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(64'd500, 64'd3);
    send_byte(8'h33, 0);
    do_reset();
    check_fetch(64'd300, "t5.partial");
    send_byte(8'h44, 0);

    // 6: reload from RUN with len 1
    do_start(64'd600, 64'd2);
    send_byte(8'h66, 0);
    send_byte(8'h77, 1);
    do_start(64'd700, 64'd1);
    send_byte(8'h99, 0);
    check_fetch(64'd600, "t6.fetch600");
    check_fetch(64'd700, "t6.fetch700");

    // Randomized loads, legal and illegal
    for (int it = 0; it < 10; it++) begin
      base = 64'($urandom_range(0, 2047));
      len  = 64'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) base = 64'($urandom_range(2020, 2047));
      do_start(base, len);
      if (m_loading) begin
        for (longint unsigned i = 0; i < len; i++)
          send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      end
      send_byte(8'($urandom_range(0, 255)), 0);
      check_fetch(base, "rnd.base");
      check_fetch(64'($urandom_range(0, 2060)), "rnd.pc");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
